// File: rtl/mode_ctrl.sv
// mode_ctrl: sequences resolution changes for the scrn_pos timing generator.
// A mode request is accepted over valid/ready, held until the last active
// pixel of the current frame, then the generator is held in reset while its
// RES select switches. Video stays blanked for a number of complete frames
// in the new mode so the sink can relock.
module mode_ctrl #(
   parameter int RST_CYCLES   = 16,  // 1..255
   parameter int BLANK_FRAMES = 2    // 0..15
) (
   input  logic        clk_pix,
   input  logic        rst_pix,
   input  logic        req_valid,
   input  logic [1:0]  req_res,
   output logic        req_ready,
   input  logic [11:0] sx,
   input  logic [11:0] sy,
   output logic [1:0]  res,
   output logic        tg_rst,
   output logic        video_en,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_EOF = 2'd1,
      RESET    = 2'd2,
      SETTLE   = 2'd3
   } state_t;

   localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);
   // Only used in SETTLE, which is unreachable when BLANK_FRAMES is 0.
   localparam logic [3:0] FRM_LAST = 4'(BLANK_FRAMES - 1);

   state_t      r_state;
   logic [1:0]  r_res;
   logic [1:0]  r_pend_res;
   logic        r_tg_rst;
   logic        r_video_en;
   logic        r_done;
   logic        r_err;
   logic [7:0]  r_cyc_cnt;
   logic [3:0]  r_frm_cnt;

   logic [11:0] w_h_last;
   logic [11:0] w_v_last;
   logic [11:0] w_h_tot;
   logic [11:0] w_v_tot;
   logic        w_last_px;
   logic        w_frame_end;
   logic        w_accept;

   // Timing constants of the mode currently driven on res.
   always_comb begin
      w_h_last = 12'd639;
      w_v_last = 12'd479;
      w_h_tot  = 12'd799;
      w_v_tot  = 12'd524;
      case (r_res)
         2'b01: begin
            w_h_last = 12'd1279;
            w_v_last = 12'd719;
            w_h_tot  = 12'd1649;
            w_v_tot  = 12'd749;
         end
         2'b10: begin
            w_h_last = 12'd1919;
            w_v_last = 12'd1079;
            w_h_tot  = 12'd2199;
            w_v_tot  = 12'd1124;
         end
         default: ;
      endcase
   end

   assign w_last_px   = (sx == w_h_last) && (sy == w_v_last);
   assign w_frame_end = (sx == w_h_tot)  && (sy == w_v_tot);
   assign w_accept    = req_valid && (r_state == IDLE);

   // Sequencer: handshake, end-of-frame trigger, reset hold, blank frames.
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         r_state    <= IDLE;
         r_res      <= 2'b00;
         r_pend_res <= 2'b00;
         r_tg_rst   <= 1'b0;
         r_video_en <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cyc_cnt  <= 8'd0;
         r_frm_cnt  <= 4'd0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pend_res <= req_res;
                  if (req_res == 2'b11)
                     r_err <= 1'b1;
                  else if (req_res == r_res)
                     r_done <= 1'b1;
                  else
                     r_state <= WAIT_EOF;
               end
            end
            WAIT_EOF: begin
               // res moves with tg_rst so the generator never counts
               // against a mismatched mode.
               if (w_last_px) begin
                  r_tg_rst   <= 1'b1;
                  r_res      <= r_pend_res;
                  r_video_en <= 1'b0;
                  r_cyc_cnt  <= RST_LOAD;
                  r_state    <= RESET;
               end
            end
            RESET: begin
               if (r_cyc_cnt == 8'd0) begin
                  r_tg_rst <= 1'b0;
                  if (BLANK_FRAMES == 0) begin
                     r_video_en <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_frm_cnt <= 4'd0;
                     r_state   <= SETTLE;
                  end
               end else begin
                  r_cyc_cnt <= r_cyc_cnt - 8'd1;
               end
            end
            SETTLE: begin
               if (w_frame_end) begin
                  if (r_frm_cnt == FRM_LAST) begin
                     r_video_en <= 1'b1;
                     r_done     <= 1'b1;
                     r_state    <= IDLE;
                  end else begin
                     r_frm_cnt <= r_frm_cnt + 4'd1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == IDLE);
   assign busy      = (r_state != IDLE);
   assign res       = r_res;
   assign tg_rst    = r_tg_rst;
   assign video_en  = r_video_en;
   assign done      = r_done;
   assign err       = r_err;

endmodule
